// File: rtl/pmp_regfile_pkg.sv
// Shared definitions for the PMP register file.
// Contents: CSR numbers, A-field encodings, cfg bit positions, FSM state
// type and a helper that classifies a CSR number as a legal PMP CSR.
package pmp_regfile_pkg;

  localparam logic [11:0] PMPCFG0  = 12'h3a0;
  localparam logic [11:0] PMPCFG2  = 12'h3a2;
  localparam logic [11:0] PMPADDR0 = 12'h3b0;

  // pmpcfg.A encodings
  typedef enum logic [1:0] {
    AOff   = 2'd0,
    ATor   = 2'd1,
    ANa4   = 2'd2,
    ANapot = 2'd3
  } pmp_a_e;

  // pmpcfg bit positions
  localparam int unsigned CfgL   = 7;
  localparam int unsigned CfgAHi = 4;
  localparam int unsigned CfgALo = 3;
  localparam int unsigned CfgX   = 2;
  localparam int unsigned CfgW   = 1;
  localparam int unsigned CfgR   = 0;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StCommit
  } pmp_state_e;

  // RV64: only even pmpcfg numbers exist.
  function automatic logic csr_is_pmp(logic [11:0] num);
    return (num == PMPCFG0) || (num == PMPCFG2) || (num[11:4] == PMPADDR0[11:4]);
  endfunction

endpackage

// File: rtl/pmp_decode_entry.sv
// Combinational decode of one PMP entry into an inclusive word-address range.
// Ports:
//   cfg       - pmpcfg byte of this entry
//   addr      - pmpaddr of this entry (physical address bits NPHYS-1:2)
//   prev_addr - pmpaddr of the preceding entry (0 for entry 0), TOR base
//   start     - inclusive lower word bound
//   aend      - inclusive upper word bound
//   prot      - {x,w,r}
//   locked    - cfg.L of a valid entry
//   valid     - entry matches a non-empty range
// Outputs are all zero for an entry that is not valid.
module pmp_decode_entry
  import pmp_regfile_pkg::*;
#(
  parameter int unsigned NPHYS = 56
) (
  input  logic [7:0]       cfg,
  input  logic [NPHYS-1:2] addr,
  input  logic [NPHYS-1:2] prev_addr,
  output logic [NPHYS-1:2] start,
  output logic [NPHYS-1:2] aend,
  output logic [2:0]       prot,
  output logic             locked,
  output logic             valid
);

  localparam int unsigned AW = NPHYS - 2;

  // addr ^ (addr + 1) sets exactly the trailing ones plus the first zero above
  // them, i.e. the low t+1 bits. All ones wraps to zero and yields all ones.
  logic [NPHYS-1:2] napot_mask;
  assign napot_mask = addr ^ (addr + AW'(1));

  logic [1:0] unused_cfg;
  assign unused_cfg = cfg[6:5];

  logic [NPHYS-1:2] range_lo;
  logic [NPHYS-1:2] range_hi;
  logic             range_ok;

  always_comb begin
    range_lo = '0;
    range_hi = '0;
    range_ok = 1'b0;
    unique case (pmp_a_e'(cfg[CfgAHi:CfgALo]))
      ATor: begin
        range_lo = prev_addr;
        range_hi = addr - AW'(1);
        range_ok = addr > prev_addr;
      end
      ANa4: begin
        range_lo = addr;
        range_hi = addr;
        range_ok = 1'b1;
      end
      ANapot: begin
        range_lo = addr & ~napot_mask;
        range_hi = addr | napot_mask;
        range_ok = 1'b1;
      end
      default: begin
        range_ok = 1'b0;
      end
    endcase
  end

  always_comb begin
    valid  = range_ok;
    start  = range_ok ? range_lo : '0;
    aend   = range_ok ? range_hi : '0;
    prot   = range_ok ? cfg[CfgX:CfgR] : 3'b000;
    locked = range_ok & cfg[CfgL];
  end

endmodule

// File: rtl/pmp_regfile.sv
// PMP register file: owns pmpcfg/pmpaddr, serves CSR reads/writes, and after
// every effective write re-decodes all entries into staging registers, then
// publishes them together on the pmp_* outputs.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   csr_wr, csr_rd      - CSR write / read strobes
//   csr_addr, csr_wdata - CSR number and write data
//   csr_rdata, csr_hit  - registered read data / legal-CSR flag
//   busy                - re-decode in progress; pmp_* still the old image
//   pmp_start, pmp_aend - inclusive word bounds per entry
//   pmp_prot            - {x,w,r} per entry
//   pmp_locked, pmp_valid
module pmp_regfile
  import pmp_regfile_pkg::*;
#(
  parameter int unsigned NPHYS   = 56,
  parameter int unsigned NUM_PMP = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              csr_wr,
  input  logic                              csr_rd,
  input  logic [11:0]                       csr_addr,
  input  logic [63:0]                       csr_wdata,
  output logic [63:0]                       csr_rdata,
  output logic                              csr_hit,
  output logic                              busy,
  output logic [NUM_PMP-1:0][NPHYS-1:2]     pmp_start,
  output logic [NUM_PMP-1:0][NPHYS-1:2]     pmp_aend,
  output logic [NUM_PMP-1:0][2:0]           pmp_prot,
  output logic [NUM_PMP-1:0]                pmp_locked,
  output logic [NUM_PMP-1:0]                pmp_valid
);

  localparam int unsigned AW = NPHYS - 2;

  // ---------------------------------------------------------------------------
  // Architectural registers and write filtering
  // ---------------------------------------------------------------------------
  logic [NUM_PMP-1:0][7:0]    cfg_q, cfg_d;
  logic [NUM_PMP-1:0][AW-1:0] addr_q, addr_d;
  logic [NUM_PMP-1:0]         tor_lock;
  logic [7:0]                 wr_byte;
  logic                       wr_cfg0, wr_cfg2, wr_addr, wr_change;

  logic unused_wdata;
  assign unused_wdata = ^csr_wdata;

  assign wr_cfg0 = csr_wr && (csr_addr == PMPCFG0);
  assign wr_cfg2 = csr_wr && (csr_addr == PMPCFG2);
  assign wr_addr = csr_wr && (csr_addr[11:4] == PMPADDR0[11:4]);

  // A locked TOR entry also freezes the pmpaddr below it (its base).
  always_comb begin
    tor_lock = '0;
    for (int i = 1; i < NUM_PMP; i++) begin
      tor_lock[i-1] = cfg_q[i][CfgL] && (cfg_q[i][CfgAHi:CfgALo] == ATor);
    end
  end

  always_comb begin
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    wr_byte = '0;
    for (int i = 0; i < NUM_PMP; i++) begin
      if ((i < 8) ? wr_cfg0 : wr_cfg2) begin
        wr_byte      = csr_wdata[8*(i%8) +: 8];
        wr_byte[6:5] = 2'b00;
        // W=1 with R=0 is reserved: keep the old byte.
        if (!cfg_q[i][CfgL] && !(wr_byte[CfgW] && !wr_byte[CfgR])) begin
          cfg_d[i] = wr_byte;
        end
      end
      if (wr_addr && (csr_addr[3:0] == 4'(i)) && !cfg_q[i][CfgL] && !tor_lock[i]) begin
        addr_d[i] = csr_wdata[AW-1:0];
      end
    end
  end

  // Only a write that actually alters state triggers a re-decode.
  assign wr_change = (cfg_d != cfg_q) || (addr_d != addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CSR read path (sees the pre-write value on a same-cycle read/write)
  // ---------------------------------------------------------------------------
  logic [63:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (csr_addr == PMPCFG0) begin
      for (int i = 0; i < NUM_PMP && i < 8; i++) begin
        rd_val[8*i +: 8] = cfg_q[i];
      end
    end else if (csr_addr == PMPCFG2) begin
      for (int i = 8; i < NUM_PMP; i++) begin
        rd_val[8*(i-8) +: 8] = cfg_q[i];
      end
    end else if (csr_addr[11:4] == PMPADDR0[11:4]) begin
      for (int i = 0; i < NUM_PMP; i++) begin
        if (csr_addr[3:0] == 4'(i)) begin
          rd_val = 64'(addr_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_rdata <= '0;
      csr_hit   <= 1'b0;
    end else begin
      if (csr_rd) begin
        csr_rdata <= rd_val;
      end
      if (csr_rd || csr_wr) begin
        csr_hit <= csr_is_pmp(csr_addr);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  pmp_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       stage_en, commit_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (wr_change) begin
      state_d = StSweep;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StSweep: begin
          if (idx_q == 4'(NUM_PMP - 1)) begin
            state_d = StCommit;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        StCommit: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    stage_en  = (state_q == StSweep);
    // A write landing in the commit cycle keeps the old image published.
    commit_en = (state_q == StCommit) && !wr_change;
  end

  // ---------------------------------------------------------------------------
  // Single shared decoder, fed from the architectural registers
  // ---------------------------------------------------------------------------
  logic [7:0]    sel_cfg;
  logic [AW-1:0] sel_addr, sel_prev;
  logic [AW-1:0] dec_start, dec_aend;
  logic [2:0]    dec_prot;
  logic          dec_locked, dec_valid;

  always_comb begin
    sel_cfg  = '0;
    sel_addr = '0;
    sel_prev = '0;
    for (int i = 0; i < NUM_PMP; i++) begin
      if (idx_q == 4'(i)) begin
        sel_cfg  = cfg_q[i];
        sel_addr = addr_q[i];
      end
    end
    for (int i = 1; i < NUM_PMP; i++) begin
      if (idx_q == 4'(i)) begin
        sel_prev = addr_q[i-1];
      end
    end
  end

  pmp_decode_entry #(
    .NPHYS(NPHYS)
  ) u_decode (
    .cfg      (sel_cfg),
    .addr     (sel_addr),
    .prev_addr(sel_prev),
    .start    (dec_start),
    .aend     (dec_aend),
    .prot     (dec_prot),
    .locked   (dec_locked),
    .valid    (dec_valid)
  );

  // ---------------------------------------------------------------------------
  // Staging and published image
  // ---------------------------------------------------------------------------
  logic [NUM_PMP-1:0][AW-1:0] stg_start, stg_aend;
  logic [NUM_PMP-1:0][2:0]    stg_prot;
  logic [NUM_PMP-1:0]         stg_locked, stg_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_start  <= '0;
      stg_aend   <= '0;
      stg_prot   <= '0;
      stg_locked <= '0;
      stg_valid  <= '0;
    end else if (stage_en) begin
      for (int i = 0; i < NUM_PMP; i++) begin
        if (idx_q == 4'(i)) begin
          stg_start[i]  <= dec_start;
          stg_aend[i]   <= dec_aend;
          stg_prot[i]   <= dec_prot;
          stg_locked[i] <= dec_locked;
          stg_valid[i]  <= dec_valid;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pmp_start  <= '0;
      pmp_aend   <= '0;
      pmp_prot   <= '0;
      pmp_locked <= '0;
      pmp_valid  <= '0;
    end else if (commit_en) begin
      pmp_start  <= stg_start;
      pmp_aend   <= stg_aend;
      pmp_prot   <= stg_prot;
      pmp_locked <= stg_locked;
      pmp_valid  <= stg_valid;
    end
  end

endmodule
